// File: rtl/atp_note_acceptor.sv
// ============================================================================
// Module   : atp_note_acceptor
// Brief    : Note sensor debounce, denomination decode, validate/offer/stack.
// Revision : 1.0
// ============================================================================
`default_nettype none

module atp_note_acceptor #(
    parameter int SENSE_CYCLES   = 4,
    parameter int STACK_CYCLES   = 8,
    parameter int RETURN_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        note_present_i,
    input  logic [2:0]  denom_code_i,
    input  logic        sensor_ok_i,
    input  logic        note_ready_i,
    input  logic        clr_total_i,
    output logic        note_valid_o,
    output logic [9:0]  note_value_o,
    output logic        stack_motor_o,
    output logic        return_motor_o,
    output logic        reject_o,
    output logic        timeout_o,
    output logic [13:0] total_paid_o,
    output logic [7:0]  note_count_o
);

    localparam int MAX_A   = (SENSE_CYCLES > STACK_CYCLES) ? SENSE_CYCLES : STACK_CYCLES;
    localparam int MAX_PH  = (MAX_A > RETURN_CYCLES) ? MAX_A : RETURN_CYCLES;
    localparam int CNT_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
    localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] SENSE_LAST   = CNT_W'(SENSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STACK_LAST   = CNT_W'(STACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETURN_LAST  = CNT_W'(RETURN_CYCLES - 1);
    localparam logic [TMO_W-1:0] TIMEOUT_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [13:0]      TOTAL_MAX    = 14'h3FFF;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SENSE      = 3'd1,
        S_OFFER      = 3'd2,
        S_STACK      = 3'd3,
        S_REJECT     = 3'd4,
        S_WAIT_CLEAR = 3'd5
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [2:0]        code_q;
    logic              note_valid_q;
    logic [9:0]        note_value_q;
    logic              stack_motor_q;
    logic              return_motor_q;
    logic              reject_q;
    logic              timeout_q;
    logic [13:0]       total_q;
    logic [13:0]       total_d;
    logic [7:0]        count_q;
    logic [7:0]        count_d;
    logic              handshake;
    logic [14:0]       sum;

    function automatic logic [9:0] denom_value(input logic [2:0] code);
        case (code)
            3'd1:    denom_value = 10'd5;
            3'd2:    denom_value = 10'd10;
            3'd3:    denom_value = 10'd20;
            3'd4:    denom_value = 10'd50;
            3'd5:    denom_value = 10'd100;
            3'd6:    denom_value = 10'd500;
            3'd7:    denom_value = 10'd1000;
            default: denom_value = 10'd0;
        endcase
    endfunction

    // A clear coinciding with a handshake restarts the session at this note.
    always_comb begin
        handshake = note_valid_q && note_ready_i;
        sum       = {1'b0, total_q} + {5'd0, note_value_q};
        total_d   = clr_total_i ? 14'd0 : total_q;
        count_d   = clr_total_i ? 8'd0 : count_q;
        if (handshake) begin
            if (clr_total_i) begin
                total_d = {4'd0, note_value_q};
                count_d = 8'd1;
            end else begin
                total_d = sum[14] ? TOTAL_MAX : sum[13:0];
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            tmo_q          <= '0;
            code_q         <= 3'd0;
            note_valid_q   <= 1'b0;
            note_value_q   <= 10'd0;
            stack_motor_q  <= 1'b0;
            return_motor_q <= 1'b0;
            reject_q       <= 1'b0;
            timeout_q      <= 1'b0;
            total_q        <= 14'd0;
            count_q        <= 8'd0;
        end else begin
            total_q   <= total_d;
            count_q   <= count_d;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;

            if (state_q == S_IDLE && en_i) begin
                if (tmo_q == TIMEOUT_LAST) begin
                    timeout_q <= 1'b1;
                    tmo_q     <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (en_i && note_present_i) begin
                        state_q <= S_SENSE;
                        code_q  <= denom_code_i;
                        cnt_q   <= '0;
                    end
                end
                S_SENSE: begin
                    if (!note_present_i) begin
                        state_q <= S_IDLE;
                    end else if (denom_code_i != code_q) begin
                        code_q <= denom_code_i;
                        cnt_q  <= '0;
                    end else if (cnt_q == SENSE_LAST) begin
                        cnt_q <= '0;
                        if (code_q == 3'd0 || !sensor_ok_i) begin
                            state_q        <= S_REJECT;
                            reject_q       <= 1'b1;
                            return_motor_q <= 1'b1;
                        end else begin
                            state_q      <= S_OFFER;
                            note_valid_q <= 1'b1;
                            note_value_q <= denom_value(code_q);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OFFER: begin
                    if (handshake) begin
                        state_q       <= S_STACK;
                        note_valid_q  <= 1'b0;
                        note_value_q  <= 10'd0;
                        stack_motor_q <= 1'b1;
                        cnt_q         <= '0;
                    end else if (!en_i) begin
                        state_q        <= S_REJECT;
                        note_valid_q   <= 1'b0;
                        note_value_q   <= 10'd0;
                        reject_q       <= 1'b1;
                        return_motor_q <= 1'b1;
                        cnt_q          <= '0;
                    end
                end
                S_STACK: begin
                    if (cnt_q == STACK_LAST) begin
                        state_q       <= S_WAIT_CLEAR;
                        stack_motor_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_REJECT: begin
                    if (cnt_q == RETURN_LAST) begin
                        state_q        <= S_WAIT_CLEAR;
                        return_motor_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Hold until the throat empties so one note is never counted twice.
                S_WAIT_CLEAR: begin
                    if (!note_present_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign note_valid_o   = note_valid_q;
    assign note_value_o   = note_value_q;
    assign stack_motor_o  = stack_motor_q;
    assign return_motor_o = return_motor_q;
    assign reject_o       = reject_q;
    assign timeout_o      = timeout_q;
    assign total_paid_o   = total_q;
    assign note_count_o   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_atp_note_acceptor.sv
// ============================================================================
// Module   : tb_atp_note_acceptor
// Brief    : Directed self-checking bench for atp_note_acceptor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_atp_note_acceptor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        note_present;
    logic [2:0]  denom_code;
    logic        sensor_ok;
    logic        note_ready;
    logic        clr_total;
    logic        note_valid;
    logic [9:0]  note_value;
    logic        stack_motor;
    logic        return_motor;
    logic        reject;
    logic        timeout;
    logic [13:0] total_paid;
    logic [7:0]  note_count;

    int tests = 0;
    int fails = 0;

    atp_note_acceptor #(
        .SENSE_CYCLES   (4),
        .STACK_CYCLES   (8),
        .RETURN_CYCLES  (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en),
        .note_present_i (note_present),
        .denom_code_i   (denom_code),
        .sensor_ok_i    (sensor_ok),
        .note_ready_i   (note_ready),
        .clr_total_i    (clr_total),
        .note_valid_o   (note_valid),
        .note_value_o   (note_value),
        .stack_motor_o  (stack_motor),
        .return_motor_o (return_motor),
        .reject_o       (reject),
        .timeout_o      (timeout),
        .total_paid_o   (total_paid),
        .note_count_o   (note_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds one note with ready=1 and waits for the motor phase and throat clear.
    task automatic run_note(input logic [2:0] code);
        bit seen = 1'b0;
        denom_code   = code;
        sensor_ok    = 1'b1;
        note_ready   = 1'b1;
        note_present = 1'b1;
        for (int n = 0; n < 40 && !seen; n++) begin
            step();
            if (stack_motor || return_motor) seen = 1'b1;
        end
        for (int n = 0; n < 40 && (stack_motor || return_motor); n++) step();
        tests++;
        if (!seen || stack_motor || return_motor) begin
            fails++;
            $display("FAIL run_note code=%0d: motor phase seen=%0b stack=%0b return=%0b, required seen=1 and both motors idle",
                     code, seen, stack_motor, return_motor);
        end
        note_present = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; note_present = 1'b0; denom_code = 3'd0;
        sensor_ok = 1'b0; note_ready = 1'b0; clr_total = 1'b0;
        step();
        step();
        tests++;
        if ({note_valid, note_value, stack_motor, return_motor, reject, timeout} !== 15'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %h, required 0",
                     {note_valid, note_value, stack_motor, return_motor, reject, timeout});
        end
        tests++;
        if ({total_paid, note_count} !== 22'd0) begin
            fails++;
            $display("FAIL reset_totals: total=%0d count=%0d, required 0/0", total_paid, note_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_accept();
        int hi = 0;
        en = 1'b1; denom_code = 3'd5; sensor_ok = 1'b1; note_ready = 1'b1; note_present = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        tests++;
        if (note_valid !== 1'b0) begin
            fails++;
            $display("FAIL accept_early: note_valid=%0b after edge 4, required 0", note_valid);
        end
        step();
        tests++;
        if (note_valid !== 1'b1 || note_value !== 10'd100) begin
            fails++;
            $display("FAIL accept_offer: valid=%0b value=%0d after edge 5, required 1/100", note_valid, note_value);
        end
        step();
        tests++;
        if (note_valid !== 1'b0 || note_value !== 10'd0 || total_paid !== 14'd100 || note_count !== 8'd1) begin
            fails++;
            $display("FAIL accept_total: valid=%0b value=%0d total=%0d count=%0d, required 0/0/100/1",
                     note_valid, note_value, total_paid, note_count);
        end
        for (int n = 0; n < 20 && stack_motor; n++) begin
            hi++;
            step();
        end
        tests++;
        if (hi != 8) begin
            fails++;
            $display("FAIL accept_stack_len: stack_motor high %0d cycles, required 8", hi);
        end
        note_present = 1'b0;
        step();
        step();
    endtask

    task automatic test_reject();
        int hi = 0;
        denom_code = 3'd0; sensor_ok = 1'b1; note_ready = 1'b1; note_present = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        tests++;
        if (reject !== 1'b1 || return_motor !== 1'b1 || note_valid !== 1'b0) begin
            fails++;
            $display("FAIL reject_entry: reject=%0b return=%0b valid=%0b, required 1/1/0", reject, return_motor, note_valid);
        end
        for (int n = 0; n < 20 && return_motor; n++) begin
            hi++;
            step();
            if (reject !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL reject_pulse: reject=%0b in cycle %0d, required 0", reject, hi + 1);
            end
        end
        tests++;
        if (hi != 8 || total_paid !== 14'd100 || note_count !== 8'd1) begin
            fails++;
            $display("FAIL reject_return: return high %0d total=%0d count=%0d, required 8/100/1",
                     hi, total_paid, note_count);
        end
        note_present = 1'b0;
        step();
        step();
        // A valid denomination with poor quality is still refused.
        denom_code = 3'd7; sensor_ok = 1'b0; note_present = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        tests++;
        if (reject !== 1'b1 || note_valid !== 1'b0) begin
            fails++;
            $display("FAIL reject_quality: reject=%0b valid=%0b, required 1/0", reject, note_valid);
        end
        for (int n = 0; n < 20 && return_motor; n++) step();
        note_present = 1'b0; sensor_ok = 1'b1;
        step();
        step();
    endtask

    task automatic test_restart();
        denom_code = 3'd3; note_ready = 1'b1; note_present = 1'b1;
        step();
        step();
        step();
        denom_code = 3'd6;
        step();
        step();
        step();
        step();
        tests++;
        if (note_valid !== 1'b0) begin
            fails++;
            $display("FAIL restart_early: valid=%0b 3 edges after relatch, required 0", note_valid);
        end
        step();
        tests++;
        if (note_valid !== 1'b1 || note_value !== 10'd500) begin
            fails++;
            $display("FAIL restart_offer: valid=%0b value=%0d, required 1/500", note_valid, note_value);
        end
        step();
        tests++;
        if (total_paid !== 14'd600 || note_count !== 8'd2) begin
            fails++;
            $display("FAIL restart_total: total=%0d count=%0d, required 600/2", total_paid, note_count);
        end
        for (int n = 0; n < 20 && stack_motor; n++) step();
        note_present = 1'b0;
        step();
        step();
    endtask

    task automatic test_hold();
        bit held = 1'b1;
        bit extra = 1'b0;
        denom_code = 3'd7; note_ready = 1'b0; note_present = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        for (int n = 0; n < 10; n++) begin
            if (note_valid !== 1'b1 || note_value !== 10'd1000) held = 1'b0;
            step();
        end
        tests++;
        if (!held || total_paid !== 14'd600) begin
            fails++;
            $display("FAIL hold_offer: held=%0b value=%0d total=%0d, required 1/1000/600", held, note_value, total_paid);
        end
        note_ready = 1'b1;
        step();
        tests++;
        if (total_paid !== 14'd1600 || note_count !== 8'd3 || stack_motor !== 1'b1) begin
            fails++;
            $display("FAIL hold_accept: total=%0d count=%0d stack=%0b, required 1600/3/1",
                     total_paid, note_count, stack_motor);
        end
        for (int n = 0; n < 30; n++) begin
            step();
            if (note_valid) extra = 1'b1;
        end
        tests++;
        if (extra || note_count !== 8'd3 || stack_motor !== 1'b0) begin
            fails++;
            $display("FAIL hold_single: second offer=%0b count=%0d stack=%0b, required 0/3/0", extra, note_count, stack_motor);
        end
        note_present = 1'b0;
        step();
        step();
    endtask

    task automatic test_saturate();
        bit seen = 1'b0;
        clr_total = 1'b1;
        step();
        clr_total = 1'b0;
        tests++;
        if (total_paid !== 14'd0 || note_count !== 8'd0) begin
            fails++;
            $display("FAIL clr_total: total=%0d count=%0d, required 0/0", total_paid, note_count);
        end
        for (int k = 0; k < 16; k++) run_note(3'd7);
        tests++;
        if (total_paid !== 14'd16000 || note_count !== 8'd16) begin
            fails++;
            $display("FAIL sat_16: total=%0d count=%0d, required 16000/16", total_paid, note_count);
        end
        run_note(3'd7);
        tests++;
        if (total_paid !== 14'd16383 || note_count !== 8'd17) begin
            fails++;
            $display("FAIL sat_17: total=%0d count=%0d, required 16383/17", total_paid, note_count);
        end
        denom_code = 3'd4; note_ready = 1'b0; note_present = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (note_valid) seen = 1'b1;
        end
        note_ready = 1'b1; clr_total = 1'b1;
        step();
        clr_total = 1'b0;
        tests++;
        if (!seen || total_paid !== 14'd50 || note_count !== 8'd1) begin
            fails++;
            $display("FAIL clr_handshake: offer_seen=%0b total=%0d count=%0d, required 1/50/1", seen, total_paid, note_count);
        end
        for (int n = 0; n < 20 && stack_motor; n++) step();
        note_present = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout_reset();
        int at = 0;
        bit ign = 1'b0;
        en = 1'b0;
        step();
        en = 1'b1;
        for (int e = 1; e <= 40 && at == 0; e++) begin
            step();
            if (timeout) at = e;
        end
        tests++;
        if (at != 20) begin
            fails++;
            $display("FAIL timeout_edge: pulse after edge %0d, required 20", at);
        end
        step();
        tests++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_pulse: timeout=%0b a cycle later, required 0", timeout);
        end
        en = 1'b0; denom_code = 3'd5; note_present = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            if (note_valid || stack_motor || reject) ign = 1'b1;
        end
        tests++;
        if (ign) begin
            fails++;
            $display("FAIL disabled_ignore: activity=%0b with en=0, required 0", ign);
        end
        en = 1'b1; note_ready = 1'b1;
        for (int n = 0; n < 20 && !stack_motor; n++) step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        tests++;
        if (stack_motor !== 1'b0 || total_paid !== 14'd0 || note_count !== 8'd0) begin
            fails++;
            $display("FAIL async_reset: stack=%0b total=%0d count=%0d, required 0/0/0", stack_motor, total_paid, note_count);
        end
        step();
        rst = 1'b0; note_present = 1'b0;
        step();
        denom_code = 3'd1; note_present = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        tests++;
        if (note_valid !== 1'b1 || note_value !== 10'd5) begin
            fails++;
            $display("FAIL after_reset: valid=%0b value=%0d, required 1/5", note_valid, note_value);
        end
        note_present = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_accept();
        test_reject();
        test_restart();
        test_hold();
        test_saturate();
        test_timeout_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
